// File: rtl/bus_fabric_n.sv
// Single-master, N-slave memory-mapped interconnect with base/mask decode and error responses.
// Latency: one decode cycle in IDLE before the slave sees the command; read data is forwarded combinationally.
// Backpressure: the selected slave's waitrequest passes to the master in CMD; the master is stalled in IDLE and RDATA.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   m_addr/m_wdata/m_read/m_write   master command
//   m_dataena/m_burstcount          master byte enables, burst length (0 means 1)
//   m_rdata/m_valid/m_err           read data beat, its valid strobe, per-beat error pulse
//   m_waitrequest                   master must hold its command while high
//   s_addr/s_wdata/s_dataena/s_burstcount  broadcast copies of the master fields
//   s_chsel/s_read/s_write          one-hot select and gated strobes per slave
//   s_rdata/s_valid/s_waitrequest   per-slave responses, slave0 in the LSBs
module bus_fabric_n #(
  parameter int                       NUM_SLAVES = 3,
  parameter int                       AW         = 32,
  parameter int                       DW         = 32,
  parameter int                       BCW        = 4,
  parameter logic [NUM_SLAVES*AW-1:0] SLV_BASE   = {32'h4000_0000, 32'h2000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*AW-1:0] SLV_MASK   = {32'hFFFF_FF00, 32'hFFFF_0000, 32'hFFFF_C000},
  parameter int                       TIMEOUT    = 256,
  parameter logic [DW-1:0]            ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AW-1:0]            m_addr,
  input  logic [DW-1:0]            m_wdata,
  input  logic                     m_read,
  input  logic                     m_write,
  input  logic [DW/8-1:0]          m_dataena,
  input  logic [BCW-1:0]           m_burstcount,
  output logic [DW-1:0]            m_rdata,
  output logic                     m_valid,
  output logic                     m_waitrequest,
  output logic                     m_err,
  output logic [AW-1:0]            s_addr,
  output logic [DW-1:0]            s_wdata,
  output logic [DW/8-1:0]          s_dataena,
  output logic [BCW-1:0]           s_burstcount,
  output logic [NUM_SLAVES-1:0]    s_chsel,
  output logic [NUM_SLAVES-1:0]    s_read,
  output logic [NUM_SLAVES-1:0]    s_write,
  input  logic [NUM_SLAVES*DW-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]    s_valid,
  input  logic [NUM_SLAVES-1:0]    s_waitrequest
);

  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, CMD, RDATA, ERR} state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  sel_q, sel_d;
  logic           is_wr_q, is_wr_d;
  logic           acc_q, acc_d;      // read command already taken by the slave
  logic [BCW-1:0] beats_q, beats_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;

  logic                  hit;
  logic [SW-1:0]         hit_idx;
  logic [NUM_SLAVES-1:0] sel_oh;
  logic                  wait_sel;
  logic                  valid_sel;
  logic [DW-1:0]         rdata_sel;
  logic                  tmo;
  logic                  req;

  assign s_addr       = m_addr;
  assign s_wdata      = m_wdata;
  assign s_dataena    = m_dataena;
  assign s_burstcount = m_burstcount;

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  // Mux the latched slave's response; compare-based so an unused sel code selects nothing.
  always_comb begin
    sel_oh    = '0;
    wait_sel  = 1'b0;
    valid_sel = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SW'(i)) begin
        sel_oh[i] = 1'b1;
        wait_sel  = s_waitrequest[i];
        valid_sel = s_valid[i];
        rdata_sel = s_rdata[i*DW +: DW];
      end
    end
  end

  assign tmo = (TIMEOUT != 0) && (tcnt_q == TW'(TIMEOUT - 1));
  assign req = is_wr_q ? m_write : m_read;

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    is_wr_d       = is_wr_q;
    acc_d         = acc_q;
    beats_d       = beats_q;
    tcnt_d        = tcnt_q;
    m_waitrequest = 1'b1;
    m_valid       = 1'b0;
    m_err         = 1'b0;
    m_rdata       = '0;
    s_chsel       = '0;
    s_read        = '0;
    s_write       = '0;

    case (state_q)
      IDLE: begin
        if (m_read || m_write) begin
          sel_d   = hit_idx;
          is_wr_d = m_write;    // write wins when both strobes are high
          acc_d   = 1'b0;
          beats_d = (m_burstcount == '0) ? BCW'(1) : m_burstcount;
          tcnt_d  = '0;
          state_d = hit ? CMD : ERR;
        end
      end

      CMD: begin
        s_chsel       = sel_oh;
        m_waitrequest = wait_sel;
        if (is_wr_q) s_write = sel_oh & {NUM_SLAVES{m_write}};
        else         s_read  = sel_oh & {NUM_SLAVES{m_read}};
        if (req && !wait_sel) begin
          tcnt_d = '0;
          if (is_wr_q) begin
            beats_d = beats_q - BCW'(1);
            if (beats_q <= BCW'(1)) state_d = IDLE;
          end else begin
            acc_d   = 1'b1;
            state_d = RDATA;
          end
        end else if (tmo) begin
          state_d = ERR;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      RDATA: begin
        s_chsel = sel_oh;
        m_rdata = rdata_sel;
        m_valid = valid_sel;
        if (valid_sel) begin
          tcnt_d  = '0;
          beats_d = beats_q - BCW'(1);
          if (beats_q <= BCW'(1)) state_d = IDLE;
        end else if (tmo) begin
          state_d = ERR;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      ERR: begin
        if (is_wr_q) begin
          // Swallow the rest of the write burst, flagging each beat.
          m_waitrequest = 1'b0;
          if (m_write) begin
            m_err   = 1'b1;
            beats_d = beats_q - BCW'(1);
            if (beats_q <= BCW'(1)) state_d = IDLE;
          end
        end else if (!acc_q) begin
          // Release the held read command once before returning error beats.
          m_waitrequest = 1'b0;
          acc_d         = 1'b1;
        end else begin
          m_valid = 1'b1;
          m_rdata = ERR_DATA;
          m_err   = 1'b1;
          beats_d = beats_q - BCW'(1);
          if (beats_q <= BCW'(1)) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Reset aborts at once: the master and slaves see idle outputs in the reset cycle itself.
    if (rst) begin
      m_waitrequest = 1'b1;
      m_valid       = 1'b0;
      m_err         = 1'b0;
      m_rdata       = '0;
      s_chsel       = '0;
      s_read        = '0;
      s_write       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      is_wr_q <= 1'b0;
      acc_q   <= 1'b0;
      beats_q <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      is_wr_q <= is_wr_d;
      acc_q   <= acc_d;
      beats_q <= beats_d;
      tcnt_q  <= tcnt_d;
    end
  end

endmodule

// File: tb/tb_bus_fabric_n.sv
// Directed bench for bus_fabric_n: stimulus sets inputs and expected outputs per cycle, a negedge process compares.
// Latency: expectations follow the one-cycle IDLE decode and the TIMEOUT-cycle error path.
// Backpressure: slave waitrequest patterns are driven explicitly per cycle.
module tb_bus_fabric_n;
  localparam int NS  = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BCW = 4;
  localparam int TMO = 8;
  localparam logic [NS*AW-1:0] BASE = {32'h4000_0000, 32'h2000_0000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] MASK = {32'hFFFF_FF00, 32'hFFFF_0000, 32'hFFFF_C000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_wdata;
  logic             m_read, m_write;
  logic [DW/8-1:0]  m_dataena;
  logic [BCW-1:0]   m_burstcount;
  logic [DW-1:0]    m_rdata;
  logic             m_valid, m_waitrequest, m_err;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic [DW/8-1:0]  s_dataena;
  logic [BCW-1:0]   s_burstcount;
  logic [NS-1:0]    s_chsel, s_read, s_write;
  logic [NS*DW-1:0] s_rdata;
  logic [NS-1:0]    s_valid, s_waitrequest;

  bus_fabric_n #(
    .NUM_SLAVES(NS), .AW(AW), .DW(DW), .BCW(BCW),
    .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(TMO), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .rst(rst),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_read(m_read), .m_write(m_write),
    .m_dataena(m_dataena), .m_burstcount(m_burstcount),
    .m_rdata(m_rdata), .m_valid(m_valid), .m_waitrequest(m_waitrequest), .m_err(m_err),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_dataena(s_dataena), .s_burstcount(s_burstcount),
    .s_chsel(s_chsel), .s_read(s_read), .s_write(s_write),
    .s_rdata(s_rdata), .s_valid(s_valid), .s_waitrequest(s_waitrequest)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en;

  logic          e_wait, e_valid, e_err, e_rd_chk;
  logic [31:0]   e_rdata;
  logic [NS-1:0] e_chsel, e_sread, e_swrite;

  // Reference decode: first slave (lowest index) whose masked base matches.
  function automatic int decode(input logic [AW-1:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) return i;
    return -1;
  endfunction

  function automatic logic [NS-1:0] oh(input int i);
    logic [NS-1:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_waitrequest", 32'(m_waitrequest), 32'(e_wait));
      chk("m_valid",       32'(m_valid),       32'(e_valid));
      chk("m_err",         32'(m_err),         32'(e_err));
      chk("s_chsel",       32'(s_chsel),       32'(e_chsel));
      chk("s_read",        32'(s_read),        32'(e_sread));
      chk("s_write",       32'(s_write),       32'(e_swrite));
      if (e_rd_chk) chk("m_rdata", m_rdata, e_rdata);
      chk("s_addr",        s_addr,             m_addr);
      chk("s_wdata",       s_wdata,            m_wdata);
      chk("s_dataena",     32'(s_dataena),     32'(m_dataena));
      chk("s_burstcount",  32'(s_burstcount),  32'(m_burstcount));
    end
  end

  task automatic ex(input logic w, input logic v, input logic e, input logic [31:0] rd,
                    input logic [NS-1:0] cs, input logic [NS-1:0] sr, input logic [NS-1:0] sw);
    e_wait = w; e_valid = v; e_err = e; e_rdata = rd;
    e_chsel = cs; e_sread = sr; e_swrite = sw; e_rd_chk = v;
  endtask

  task automatic ex_idle();
    ex(1'b1, 1'b0, 1'b0, 32'h0, 3'b000, 3'b000, 3'b000);
  endtask

  task automatic ex_reset();
    ex_idle();
    e_rd_chk = 1'b1;   // m_rdata must read zero while in reset
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sd(input int i, input logic [31:0] d);
    s_rdata[i*DW +: DW] = d;
  endtask

  logic [31:0] t2d [5] = '{32'd23, 32'd0, 32'd24, 32'd25, 32'd26};
  logic        t2v [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  int sel;

  initial begin
    chk_en = 1'b0;
    rst = 1'b1;
    m_addr = '0; m_wdata = '0; m_read = 1'b0; m_write = 1'b0;
    m_dataena = '0; m_burstcount = '0;
    s_rdata = '0; s_valid = '0; s_waitrequest = '0;
    ex_reset();
    tick();
    chk_en = 1'b1;
    tick(); tick();
    rst = 1'b0; ex_idle(); tick();

    // 1: RAM write, slave1 stalls two cycles
    m_addr = 32'h2000_0010; m_wdata = 32'd150; m_dataena = 4'hF; m_burstcount = 4'd1;
    m_write = 1'b1; s_waitrequest = 3'b111;
    ex_idle(); tick();
    ex(1'b1, 1'b0, 1'b0, 32'h0, 3'b010, 3'b000, 3'b010); tick(); tick();
    s_waitrequest = 3'b000;
    ex(1'b0, 1'b0, 1'b0, 32'h0, 3'b010, 3'b000, 3'b010); tick();
    m_write = 1'b0; ex_idle(); tick();

    // 2: UFM read burst 4 with a gap; slave1 strobes valid in the gap
    m_addr = 32'h0000_0000; m_burstcount = 4'd4; m_read = 1'b1;
    ex_idle(); tick();
    ex(1'b0, 1'b0, 1'b0, 32'h0, 3'b001, 3'b001, 3'b000); tick();
    m_read = 1'b0;
    for (int k = 0; k < 5; k++) begin
      s_valid = {2'b00, t2v[k]};
      set_sd(0, t2d[k]);
      if (!t2v[k]) begin s_valid[1] = 1'b1; set_sd(1, 32'd99); end
      ex(1'b1, t2v[k], 1'b0, t2d[k], 3'b001, 3'b000, 3'b000); tick();
    end
    s_valid = '0; ex_idle(); tick();

    // 3: decode miss read
    m_addr = 32'h8000_0000; m_burstcount = 4'd1; m_read = 1'b1;
    ex_idle(); tick();
    ex(1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 3'b000, 3'b000); tick();
    m_read = 1'b0;
    ex(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 3'b000, 3'b000, 3'b000); tick();
    ex_idle(); tick();

    // 4: SEG write with waitrequest stuck high -> timeout
    m_addr = 32'h4000_0000; m_wdata = 32'd7; m_burstcount = 4'd1; m_write = 1'b1;
    s_waitrequest = 3'b100;
    ex_idle(); tick();
    ex(1'b1, 1'b0, 1'b0, 32'h0, 3'b100, 3'b000, 3'b100);
    repeat (TMO) tick();
    ex(1'b0, 1'b0, 1'b1, 32'h0, 3'b000, 3'b000, 3'b000); tick();
    m_write = 1'b0; s_waitrequest = 3'b000; ex_idle(); tick();

    // 5: RAM read burst 3, slave goes silent after one beat
    m_addr = 32'h2000_0100; m_burstcount = 4'd3; m_read = 1'b1;
    ex_idle(); tick();
    ex(1'b0, 1'b0, 1'b0, 32'h0, 3'b010, 3'b010, 3'b000); tick();
    m_read = 1'b0; s_valid = 3'b010; set_sd(1, 32'h1234_5678);
    ex(1'b1, 1'b1, 1'b0, 32'h1234_5678, 3'b010, 3'b000, 3'b000); tick();
    s_valid = 3'b000;
    ex(1'b1, 1'b0, 1'b0, 32'h0, 3'b010, 3'b000, 3'b000);
    repeat (TMO) tick();
    ex(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 3'b000, 3'b000, 3'b000); tick(); tick();
    s_valid = 3'b010;   // late response must be ignored
    ex_idle(); tick();
    s_valid = 3'b000;

    // 6: reset mid burst, then a normal read with burstcount 0
    m_addr = 32'h0000_0100; m_burstcount = 4'd4; m_read = 1'b1;
    ex_idle(); tick();
    ex(1'b0, 1'b0, 1'b0, 32'h0, 3'b001, 3'b001, 3'b000); tick();
    m_read = 1'b0; s_valid = 3'b001; set_sd(0, 32'hA1);
    ex(1'b1, 1'b1, 1'b0, 32'hA1, 3'b001, 3'b000, 3'b000); tick();
    set_sd(0, 32'hA2); rst = 1'b1;
    ex_reset(); tick();
    rst = 1'b0; ex_idle(); tick();
    s_valid = 3'b000;
    m_addr = 32'h4000_0004; m_burstcount = 4'd0; m_read = 1'b1;
    sel = decode(m_addr);
    ex_idle(); tick();
    ex(1'b0, 1'b0, 1'b0, 32'h0, oh(sel), oh(sel), 3'b000); tick();
    m_read = 1'b0; s_valid = oh(sel); set_sd(sel, 32'hC5);
    ex(1'b1, 1'b1, 1'b0, 32'hC5, oh(sel), 3'b000, 3'b000); tick();
    s_valid = 3'b000; ex_idle(); tick();

    // 7: read and write together -> write only
    m_addr = 32'h2000_0020; m_burstcount = 4'd1; m_read = 1'b1; m_write = 1'b1;
    ex_idle(); tick();
    ex(1'b0, 1'b0, 1'b0, 32'h0, 3'b010, 3'b000, 3'b010); tick();
    m_read = 1'b0; m_write = 1'b0; ex_idle(); tick();

    @(posedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
